// File: rtl/bus_responder_65c02.sv
// Responder end of the 65C02 bus: on-chip RAM window with wait states,
// write-protected upper region and hard-wired reset vector.
module bus_responder_65c02 #(
    parameter logic [15:0] BASE_ADDR   = 16'h0000,
    parameter int          ADDR_W      = 12,
    parameter int unsigned ROM_OFFSET  = 32'hC00,
    parameter int          WAIT_STATES = 1,
    parameter logic [15:0] RESET_VEC   = 16'hE000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        phi2,
    input  logic [15:0] a,
    input  logic        rwb,
    input  logic        vpb,
    input  logic [7:0]  d_from_cpu,
    output logic [7:0]  d_to_cpu,
    output logic        d_oe,
    output logic        rdy,
    output logic        hit,
    output logic        wr_blocked,
    output logic        abort
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_ACCESS = 2'd2,
        S_HOLD   = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                phi2_q;
    logic [ADDR_W-1:0]   off_q;
    logic                rwb_q;
    logic                vec_q;
    logic                hit_q, hit_d;
    logic [7:0]          d_to_cpu_q, d_to_cpu_d;
    logic                d_oe_q, d_oe_d;
    logic                wr_blocked_q, wr_blocked_d;
    logic                abort_q, abort_d;
    logic                mem_we;
    logic [7:0]          mem_q [2**ADDR_W];

    logic rise;
    logic vec_in;
    logic claim_in;
    logic writable;
    logic [7:0] rd_data;

    assign rise   = phi2 & ~phi2_q;
    assign vec_in = ~vpb & rwb & (a[15:1] == 15'h7FFE);
    // Decode from the live bus on the rise edge; a_q/vec_q capture the same values
    assign claim_in = vec_in | (a[15:ADDR_W] == BASE_ADDR[15:ADDR_W]);
    assign writable = {{(32-ADDR_W){1'b0}}, off_q} < ROM_OFFSET;
    assign rd_data  = vec_q ? (off_q[0] ? RESET_VEC[15:8] : RESET_VEC[7:0])
                            : mem_q[off_q];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            phi2_q       <= 1'b0;
            off_q        <= '0;
            rwb_q        <= 1'b1;
            vec_q        <= 1'b0;
            hit_q        <= 1'b0;
            d_to_cpu_q   <= '0;
            d_oe_q       <= 1'b0;
            wr_blocked_q <= 1'b0;
            abort_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            phi2_q       <= phi2;
            hit_q        <= hit_d;
            d_to_cpu_q   <= d_to_cpu_d;
            d_oe_q       <= d_oe_d;
            wr_blocked_q <= wr_blocked_d;
            abort_q      <= abort_d;
            if (state_q == S_IDLE && rise) begin
                off_q <= a[ADDR_W-1:0];
                rwb_q <= rwb;
                vec_q <= vec_in;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we)
            mem_q[off_q] <= d_from_cpu;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (rise && claim_in) begin
                    if (WAIT_STATES > 0) begin
                        state_d = S_WAIT;
                        cnt_d   = 4'(WAIT_STATES);
                    end else begin
                        state_d = S_ACCESS;
                    end
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (!phi2)
                    state_d = S_IDLE;
                else if (cnt_q == 4'd1)
                    state_d = S_ACCESS;
            end
            S_ACCESS: begin
                state_d = phi2 ? S_HOLD : S_IDLE;
            end
            S_HOLD: begin
                if (!phi2)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        hit_d        = hit_q;
        d_to_cpu_d   = d_to_cpu_q;
        d_oe_d       = d_oe_q;
        wr_blocked_d = 1'b0;
        abort_d      = 1'b0;
        mem_we       = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (rise)
                    hit_d = claim_in;
            end
            S_WAIT: begin
                if (!phi2) begin
                    abort_d = 1'b1;
                    hit_d   = 1'b0;
                    d_oe_d  = 1'b0;
                end
            end
            S_ACCESS: begin
                if (!phi2) begin
                    abort_d = 1'b1;
                    hit_d   = 1'b0;
                    d_oe_d  = 1'b0;
                end else if (rwb_q) begin
                    d_to_cpu_d = rd_data;
                    d_oe_d     = 1'b1;
                end else if (writable) begin
                    mem_we = ~reset;
                end else begin
                    wr_blocked_d = 1'b1;
                end
            end
            S_HOLD: begin
                if (!phi2) begin
                    d_oe_d = 1'b0;
                    hit_d  = 1'b0;
                end
            end
            default: ;
        endcase
    end

    assign rdy        = (state_q != S_WAIT);
    assign d_to_cpu   = d_to_cpu_q;
    assign d_oe       = d_oe_q;
    assign hit        = hit_q;
    assign wr_blocked = wr_blocked_q;
    assign abort      = abort_q;

endmodule
